// File: rtl/muldiv_sched.sv
// Multi-cycle multiply/divide scheduler with architectural HI/LO registers.
// A mult/div result is computed in the issue cycle and held pending. It is
// committed to HI/LO when the fixed-latency countdown expires, so the
// visible timing matches a real iterative unit.
module muldiv_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [3:0]  E_MulDivOp,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    output logic        E_MulDiv_busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] E_MulDiv_out
);

    localparam int unsigned MaxCycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    typedef enum logic [3:0] {
        OpNone  = 4'd0,
        OpMult  = 4'd1,
        OpMultu = 4'd2,
        OpDiv   = 4'd3,
        OpDivu  = 4'd4,
        OpMthi  = 4'd5,
        OpMtlo  = 4'd6,
        OpMfhi  = 4'd7,
        OpMflo  = 4'd8
    } op_e;

    // Decoded operation
    logic is_mult, is_multu, is_div, is_divu, is_mthi, is_mtlo, is_mfhi, is_mflo;

    // Scheduler control
    logic            idle;
    logic            start;
    logic            wr_hi;
    logic            wr_lo;
    logic            commit;

    // State
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pend_valid_q, pend_valid_d;
    logic [31:0]     pend_hi_q, pend_hi_d;
    logic [31:0]     pend_lo_q, pend_lo_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;

    // Datapath
    logic [63:0]     mul_a, mul_b, prod;
    logic            a_neg, b_neg;
    logic [31:0]     div_ua, div_ub;
    logic [31:0]     div_uq, div_ur;
    logic [31:0]     div_q, div_r;
    logic [31:0]     res_hi, res_lo;
    logic            res_valid;

    // Decode the op code; 9..15 fall through as no-ops
    always_comb begin
        is_mult  = 1'b0;
        is_multu = 1'b0;
        is_div   = 1'b0;
        is_divu  = 1'b0;
        is_mthi  = 1'b0;
        is_mtlo  = 1'b0;
        is_mfhi  = 1'b0;
        is_mflo  = 1'b0;
        case (E_MulDivOp)
            OpMult:  is_mult  = 1'b1;
            OpMultu: is_multu = 1'b1;
            OpDiv:   is_div   = 1'b1;
            OpDivu:  is_divu  = 1'b1;
            OpMthi:  is_mthi  = 1'b1;
            OpMtlo:  is_mtlo  = 1'b1;
            OpMfhi:  is_mfhi  = 1'b1;
            OpMflo:  is_mflo  = 1'b1;
            default: ;
        endcase
    end

    // Issue qualification: a flush or an in-flight operation blocks every new op
    always_comb begin
        idle   = (cnt_q == '0);
        start  = (is_mult | is_multu | is_div | is_divu) & ~Req & idle;
        wr_hi  = is_mthi & ~Req & idle;
        wr_lo  = is_mtlo & ~Req & idle;
        commit = (cnt_q == CntW'(1)) & pend_valid_q;
    end

    // 64-bit product: sign- or zero-extend, then keep the low 64 bits
    always_comb begin
        mul_a = is_mult ? {{32{E_A[31]}}, E_A} : {32'd0, E_A};
        mul_b = is_mult ? {{32{E_B[31]}}, E_B} : {32'd0, E_B};
        prod  = mul_a * mul_b;
    end

    // Divide on magnitudes, then restore signs: quotient truncates toward
    // zero and the remainder follows the dividend
    always_comb begin
        a_neg  = is_div & E_A[31];
        b_neg  = is_div & E_B[31];
        div_ua = a_neg ? (32'd0 - E_A) : E_A;
        div_ub = b_neg ? (32'd0 - E_B) : E_B;
        // Substitute 1 for a zero divisor; that result is discarded anyway
        if (div_ub == 32'd0) begin
            div_ub = 32'd1;
        end
        div_uq = div_ua / div_ub;
        div_ur = div_ua % div_ub;
        div_q  = (a_neg ^ b_neg) ? (32'd0 - div_uq) : div_uq;
        div_r  = a_neg ? (32'd0 - div_ur) : div_ur;
    end

    // Select the result for the op being issued
    always_comb begin
        res_hi    = prod[63:32];
        res_lo    = prod[31:0];
        res_valid = 1'b1;
        if (is_div | is_divu) begin
            res_hi    = div_r;
            res_lo    = div_q;
            res_valid = (E_B != 32'd0);
        end
    end

    // Countdown and pending-result next state
    always_comb begin
        cnt_d        = cnt_q;
        pend_valid_d = pend_valid_q;
        pend_hi_d    = pend_hi_q;
        pend_lo_d    = pend_lo_q;
        if (start) begin
            cnt_d        = (is_div | is_divu) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
            pend_valid_d = res_valid;
            pend_hi_d    = res_hi;
            pend_lo_d    = res_lo;
        end else if (!idle) begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
                pend_valid_d = 1'b0;
            end
        end
    end

    // HI/LO next state; commit and mthi/mtlo are mutually exclusive by idle
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (commit) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
        end
        if (wr_hi) begin
            hi_d = E_A;
        end
        if (wr_lo) begin
            lo_d = E_A;
        end
    end

    // State registers, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_hi_q    <= 32'd0;
            pend_lo_q    <= 32'd0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
        end else begin
            cnt_q        <= cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_hi_q    <= pend_hi_d;
            pend_lo_q    <= pend_lo_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
        end
    end

    // Outputs: busy covers the issue cycle plus the countdown
    always_comb begin
        E_MulDiv_busy = start | ~idle;
        HI            = hi_q;
        LO            = lo_q;
        E_MulDiv_out  = 32'd0;
        if (is_mfhi) begin
            E_MulDiv_out = hi_q;
        end else if (is_mflo) begin
            E_MulDiv_out = lo_q;
        end
    end

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: latency, arithmetic, flush, reset, protection.
module tb_muldiv_sched;

    logic        clk;
    logic        reset;
    logic        Req;
    logic [3:0]  E_MulDivOp;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        E_MulDiv_busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] E_MulDiv_out;

    int total = 0;
    int bad   = 0;

    muldiv_sched #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Req          (Req),
        .E_MulDivOp   (E_MulDivOp),
        .E_A          (E_A),
        .E_B          (E_B),
        .E_MulDiv_busy(E_MulDiv_busy),
        .HI           (HI),
        .LO           (LO),
        .E_MulDiv_out (E_MulDiv_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op and count consecutive busy cycles (bounded); returns at the
    // negedge of the first non-busy cycle
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        @(posedge clk); #1;
        E_MulDivOp = op; E_A = a; E_B = b;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!E_MulDiv_busy) break;
            n++;
            @(posedge clk); #1;
            E_MulDivOp = 4'd0;
        end
        E_MulDivOp = 4'd0;
    endtask

    // Issue mthi/mtlo for one cycle, with optional flush
    task automatic move_to(input logic [3:0] op, input logic [31:0] a, input logic req,
                           output logic busy_seen);
        @(posedge clk); #1;
        E_MulDivOp = op; E_A = a; Req = req;
        @(negedge clk);
        busy_seen = E_MulDiv_busy;
        @(posedge clk); #1;
        E_MulDivOp = 4'd0; Req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #3;
        total++; if (E_MulDiv_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", E_MulDiv_busy); end
        total++; if (HI !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=0", HI); end
        total++; if (LO !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", LO); end
        total++; if (E_MulDiv_out !== 32'd0) begin bad++; $display("FAIL reset_out got=%h exp=0", E_MulDiv_out); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mult();
        int n;
        run_op(4'd1, 32'hFFFFFFFE, 32'd3, n);
        total++; if (n !== 6) begin bad++; $display("FAIL mult_busy got=%0d exp=6", n); end
        total++; if (HI !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", HI); end
        total++; if (LO !== 32'hFFFFFFFA) begin bad++; $display("FAIL mult_lo got=%h exp=fffffffa", LO); end
        run_op(4'd2, 32'hFFFFFFFE, 32'd3, n);
        total++; if (n !== 6) begin bad++; $display("FAIL multu_busy got=%0d exp=6", n); end
        total++; if (HI !== 32'h00000002) begin bad++; $display("FAIL multu_hi got=%h exp=00000002", HI); end
        total++; if (LO !== 32'hFFFFFFFA) begin bad++; $display("FAIL multu_lo got=%h exp=fffffffa", LO); end
    endtask

    task automatic test_div();
        int n;
        logic bz;
        run_op(4'd3, 32'hFFFFFFF9, 32'd2, n);
        total++; if (n !== 11) begin bad++; $display("FAIL div_busy got=%0d exp=11", n); end
        total++; if (LO !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_lo got=%h exp=fffffffd", LO); end
        total++; if (HI !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_hi got=%h exp=ffffffff", HI); end
        move_to(4'd5, 32'h11, 1'b0, bz);
        move_to(4'd6, 32'h22, 1'b0, bz);
        total++; if (HI !== 32'h11 || LO !== 32'h22) begin bad++; $display("FAIL mt_setup got=%h/%h exp=11/22", HI, LO); end
        run_op(4'd4, 32'd7, 32'd0, n);
        total++; if (n !== 11) begin bad++; $display("FAIL divz_busy got=%0d exp=11", n); end
        total++; if (HI !== 32'h11) begin bad++; $display("FAIL divz_hi got=%h exp=11", HI); end
        total++; if (LO !== 32'h22) begin bad++; $display("FAIL divz_lo got=%h exp=22", LO); end
    endtask

    task automatic test_move_flush();
        logic bz;
        move_to(4'd5, 32'h1234, 1'b1, bz);
        total++; if (bz !== 1'b0) begin bad++; $display("FAIL mthi_req_busy got=%0b exp=0", bz); end
        total++; if (HI !== 32'h11) begin bad++; $display("FAIL mthi_req_hi got=%h exp=11", HI); end
        move_to(4'd5, 32'h1234, 1'b0, bz);
        total++; if (bz !== 1'b0) begin bad++; $display("FAIL mthi_busy got=%0b exp=0", bz); end
        total++; if (HI !== 32'h1234) begin bad++; $display("FAIL mthi_hi got=%h exp=1234", HI); end
        @(posedge clk); #1; E_MulDivOp = 4'd8;
        @(negedge clk);
        total++; if (E_MulDiv_out !== 32'h22) begin bad++; $display("FAIL mflo_out got=%h exp=22", E_MulDiv_out); end
        @(posedge clk); #1; E_MulDivOp = 4'd7;
        @(negedge clk);
        total++; if (E_MulDiv_out !== 32'h1234) begin bad++; $display("FAIL mfhi_out got=%h exp=1234", E_MulDiv_out); end
        @(posedge clk); #1; E_MulDivOp = 4'd12;
        @(negedge clk);
        total++; if (E_MulDiv_out !== 32'd0 || E_MulDiv_busy !== 1'b0) begin
            bad++; $display("FAIL op12 got out=%h busy=%0b exp=0/0", E_MulDiv_out, E_MulDiv_busy);
        end
        @(posedge clk); #1; E_MulDivOp = 4'd0;
    endtask

    // Second mult held in D starts in the first idle cycle (t+6)
    task automatic test_back_to_back();
        @(posedge clk); #1; E_MulDivOp = 4'd1; E_A = 32'd2; E_B = 32'd3;
        @(posedge clk); #1; E_A = 32'd4; E_B = 32'd5;
        repeat (5) @(posedge clk);
        @(negedge clk);
        total++; if (E_MulDiv_busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%0b exp=1", E_MulDiv_busy); end
        total++; if (HI !== 32'd0 || LO !== 32'd6) begin bad++; $display("FAIL b2b_first got=%h/%h exp=0/6", HI, LO); end
        @(posedge clk); #1; E_MulDivOp = 4'd0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        total++; if (HI !== 32'd0 || LO !== 32'd20 || E_MulDiv_busy !== 1'b0) begin
            bad++; $display("FAIL b2b_second got=%h/%h busy=%0b exp=0/14/0", HI, LO, E_MulDiv_busy);
        end
    endtask

    task automatic test_req_start();
        @(posedge clk); #1; E_MulDivOp = 4'd1; E_A = 32'd3; E_B = 32'd3; Req = 1'b1;
        @(negedge clk);
        total++; if (E_MulDiv_busy !== 1'b0) begin bad++; $display("FAIL req_start_busy got=%0b exp=0", E_MulDiv_busy); end
        @(posedge clk); #1; E_MulDivOp = 4'd0; Req = 1'b0;
        @(negedge clk);
        total++; if (E_MulDiv_busy !== 1'b0) begin bad++; $display("FAIL req_start_cnt got=%0b exp=0", E_MulDiv_busy); end
        repeat (8) @(negedge clk);
        total++; if (LO !== 32'd20 || HI !== 32'd0) begin bad++; $display("FAIL req_start_hilo got=%h/%h exp=0/14", HI, LO); end
    endtask

    task automatic test_mtlo_in_flight();
        logic bz;
        move_to(4'd5, 32'h99, 1'b0, bz);
        @(posedge clk); #1; E_MulDivOp = 4'd1; E_A = 32'd5; E_B = 32'd7;
        @(posedge clk); #1; E_MulDivOp = 4'd0;
        @(posedge clk); #1; E_MulDivOp = 4'd6; E_A = 32'h55;
        @(posedge clk); #1; E_MulDivOp = 4'd0;
        @(negedge clk);
        total++; if (LO !== 32'd20) begin bad++; $display("FAIL mtlo_flight_lo got=%h exp=14", LO); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (HI !== 32'd0 || LO !== 32'd35 || E_MulDiv_busy !== 1'b0) begin
            bad++; $display("FAIL mtlo_flight_commit got=%h/%h busy=%0b exp=0/23/0", HI, LO, E_MulDiv_busy);
        end
    endtask

    task automatic test_reset_mid_div();
        @(posedge clk); #1; E_MulDivOp = 4'd3; E_A = 32'd100; E_B = 32'd7;
        @(posedge clk); #1; E_MulDivOp = 4'd0;
        @(posedge clk); #1; reset = 1'b1;
        #1;
        total++; if (E_MulDiv_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%0b exp=0", E_MulDiv_busy); end
        total++; if (HI !== 32'd0 || LO !== 32'd0) begin bad++; $display("FAIL rst_mid_hilo got=%h/%h exp=0/0", HI, LO); end
        @(negedge clk); reset = 1'b0;
        repeat (12) @(negedge clk);
        total++; if (HI !== 32'd0 || LO !== 32'd0 || E_MulDiv_busy !== 1'b0) begin
            bad++; $display("FAIL rst_mid_nocommit got=%h/%h busy=%0b exp=0/0/0", HI, LO, E_MulDiv_busy);
        end
    endtask

    initial begin
        reset = 1'b1; Req = 1'b0; E_MulDivOp = 4'd0; E_A = 32'd0; E_B = 32'd0;
        test_reset();
        test_mult();
        test_div();
        test_move_flush();
        test_back_to_back();
        test_req_start();
        test_mtlo_in_flight();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Multi-cycle multiply/divide scheduler for the P7 pipeline, sitting in the E stage beside the ALU. It owns the HI/LO registers and accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo operations. It sequences each multiply or divide over a fixed latency and reports `busy` so hazard detection can stall any later HI/LO-using instruction held in D. It suppresses new operations when an exception/interrupt request flushes the pipeline.

## Interface
- `MULT_CYCLES`, 5: busy cycles after a mult/multu start cycle
- `DIV_CYCLES`, 10: busy cycles after a div/divu start cycle
- `clk` input 1: single clock, rising edge
- `reset` input 1: asynchronous, active-high; clears all state
- `Req` input 1: exception/interrupt flush this cycle; the current `E_MulDivOp` is discarded
- `E_MulDivOp` input 4: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9–15 treated as none
- `E_A` input 32: rs operand (dividend / multiplicand / mthi-mtlo data)
- `E_B` input 32: rt operand (divisor / multiplier)
- `E_MulDiv_busy` output 1: combinational, `start | (cnt != 0)`
- `HI`, `LO` output 32: architectural registers
- `E_MulDiv_out` output 32: `HI` for mfhi, `LO` for mflo, else 0

## Operation
- `start` = (op ∈ {1..4}) & !Req & (cnt == 0).
- `wr_hi` = (op == 5) & !Req & (cnt == 0); `wr_lo` is the same with op 6.
- On a start edge:
  - The 64-bit result is computed from `E_A`/`E_B` and latched into `pend_hi`/`pend_lo`.
  - `cnt` loads `MULT_CYCLES` or `DIV_CYCLES`.
  - A `pend_valid` flag is set.
- While `cnt != 0`:
  - `cnt` decrements each edge.
  - On the edge where `cnt == 1`, `pend_hi`/`pend_lo` are committed to `HI`/`LO` if `pend_valid`.
- Arithmetic:
  - mult: {HI,LO} = signed 32×32 → 64.
  - multu: {HI,LO} = unsigned 32×32 → 64.
  - div: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
  - divu: unsigned quotient and remainder.
- Divide by zero (`E_B == 0`, div or divu): full `DIV_CYCLES` busy period runs, `pend_valid` is cleared, and HI/LO are unchanged.
- mthi/mtlo: `E_A` is written to HI/LO at the end of the issue cycle; `busy` is not asserted.
- mfhi/mflo: read registered `HI`/`LO`; no state change.
- Any op arriving while `cnt != 0` has no effect, including mthi/mtlo. Hazard detection stalls such ops in D, so this is a protection path only.
- `Req` cancels only an op issued in its own cycle. An operation already in flight completes and commits, because it belongs to an instruction older than the exception point.
- Reset: `cnt`=0, `pend_valid`=0, `HI`=`LO`=0, pending results discarded. `E_MulDiv_busy`=0 and `E_MulDiv_out`=0 once `E_MulDivOp` is 0.

## Timing
- mult issued in cycle t:
  - `busy`=1 in cycles t..t+5 (t through the start term, t+1..t+5 through `cnt` 5..1).
  - Commit on the edge ending t+5; new HI/LO visible in t+6, when `busy`=0.
- div: `busy` is high for cycles t..t+10; HI/LO are visible in t+11.
- Back-to-back: a new start is legal in the first cycle in which `cnt == 0`, i.e. t+6 for mult.
- mthi in cycle t: HI shows the new value in t+1. mfhi in t+1 returns it.
- Reset asserted mid-operation: all state clears immediately (async) and the pending result is never committed.
- `Req` together with a start in the same cycle: no load, `busy` stays low, HI/LO unchanged.

## Test plan
- mult, `E_A`=0xFFFFFFFE, `E_B`=3 → `busy` high exactly 6 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div, `E_A`=0xFFFFFFF9 (−7), `E_B`=2 → `busy` 11 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu, 7/0 after `HI`=0x11, `LO`=0x22 → `busy` 11 cycles; HI=0x11 and LO=0x22 are unchanged.
- mthi 0x1234 with `Req`=1 → HI unchanged. Repeat with `Req`=0 → HI=0x1234 next cycle, `busy` never 1. Then mflo → `E_MulDiv_out`=LO.
- Start div, assert `reset` in its 3rd busy cycle → `busy`=0 and HI=LO=0 immediately; no commit afterwards.
- Issue mtlo 0x55 while a mult is in flight → LO unaffected; the mult result commits normally.
